// File: rtl/bios_pkg.sv
// Shared types and constants for the bios_loader boot monitor.
// Optional feature macro: BIOS_LOADER_ACK_EN (acknowledge/NAK bytes via S_ACK).
package bios_pkg;

  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_BOOT    = 8'h01,
    OP_RST     = 8'h02,
    OP_READ    = 8'h03,
    OP_WRITE   = 8'h04,
    OP_SETADDR = 8'h05
  } bios_opcode_t;

  typedef enum logic [3:0] {
    S_OPCODE,
    S_ARG,
    S_WRITE,
    S_RDREQ,
    S_RDWAIT,
    S_SEND,
    S_RST,
    S_RUN
`ifdef BIOS_LOADER_ACK_EN
    , S_ACK
`endif
  } bios_state_t;

  localparam logic [7:0] BIOS_ACK_BYTE = 8'hA5;
  localparam logic [7:0] BIOS_NAK_BYTE = 8'h5A;

  // Where WRITE, SETADDR and RST go once their work is finished.
`ifdef BIOS_LOADER_ACK_EN
  localparam bios_state_t S_CMD_DONE = S_ACK;
`else
  localparam bios_state_t S_CMD_DONE = S_OPCODE;
`endif

  function automatic int bios_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bios_loader_if.sv
// Bus bundle of bios_loader: RAM port, CPU reset/status, host and CPU byte streams.
// "master" is the loader side, "slave" is the surrounding system (RAM, host, CPU).
interface bios_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    o_rst;
  logic                    o_booted;
  logic                    o_read_req;
  logic [ADDR_WIDTH-1:0]   o_read_addr;
  logic [DATA_WIDTH-1:0]   i_read_data;
  logic                    o_write_enable;
  logic [DATA_WIDTH/8-1:0] o_byte_enable;
  logic [ADDR_WIDTH-1:0]   o_write_addr;
  logic [DATA_WIDTH-1:0]   o_write_data;
  logic [7:0]              i_data;
  logic                    i_valid;
  logic                    o_in_ready;
  logic [7:0]              o_data;
  logic                    o_valid;
  logic                    i_out_ready;
  logic [7:0]              o_cpu_rx_data;
  logic                    o_cpu_rx_valid;
  logic                    i_cpu_rx_ready;
  logic [7:0]              i_cpu_tx_data;
  logic                    i_cpu_tx_valid;
  logic                    o_cpu_tx_ready;

  modport master (
    output o_rst, o_booted, o_read_req, o_read_addr, o_write_enable,
           o_byte_enable, o_write_addr, o_write_data, o_in_ready,
           o_data, o_valid, o_cpu_rx_data, o_cpu_rx_valid, o_cpu_tx_ready,
    input  i_read_data, i_data, i_valid, i_out_ready, i_cpu_rx_ready,
           i_cpu_tx_data, i_cpu_tx_valid
  );

  modport slave (
    input  o_rst, o_booted, o_read_req, o_read_addr, o_write_enable,
           o_byte_enable, o_write_addr, o_write_data, o_in_ready,
           o_data, o_valid, o_cpu_rx_data, o_cpu_rx_valid, o_cpu_tx_ready,
    output i_read_data, i_data, i_valid, i_out_ready, i_cpu_rx_ready,
           i_cpu_tx_data, i_cpu_tx_valid
  );
endinterface

// File: rtl/bios_stream_mux.sv
// Steers both byte-stream directions: to the loader FSM in BOOT mode,
// straight through to the CPU UART/GPIO channel in RUN mode (no clock involved).
module bios_stream_mux (
  input  logic       booted_i,
  input  logic       fsm_in_ready_i,
  input  logic [7:0] fsm_data_i,
  input  logic       fsm_valid_i,
  input  logic [7:0] host_data_i,
  input  logic       host_valid_i,
  output logic       host_in_ready_o,
  output logic [7:0] host_out_data_o,
  output logic       host_out_valid_o,
  input  logic       host_out_ready_i,
  output logic [7:0] cpu_rx_data_o,
  output logic       cpu_rx_valid_o,
  input  logic       cpu_rx_ready_i,
  input  logic [7:0] cpu_tx_data_i,
  input  logic       cpu_tx_valid_i,
  output logic       cpu_tx_ready_o
);

  // Route streams by mode; BOOT-mode values double as the defaults.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    host_in_ready_o  = fsm_in_ready_i;
    host_out_data_o  = fsm_data_i;
    host_out_valid_o = fsm_valid_i;
    cpu_rx_data_o    = 8'h00;
    cpu_rx_valid_o   = 1'b0;
    cpu_tx_ready_o   = 1'b0;
    if (booted_i) begin
      cpu_rx_data_o    = host_data_i;
      cpu_rx_valid_o   = host_valid_i;
      host_in_ready_o  = cpu_rx_ready_i;
      host_out_data_o  = cpu_tx_data_i;
      host_out_valid_o = cpu_tx_valid_i;
      cpu_tx_ready_o   = host_out_ready_i;
    end
  end

endmodule

// File: rtl/bios_loader.sv
// Boot monitor: decodes host byte commands (set address, write/read RAM words,
// pulse CPU reset) until BOOT, then hands both streams to the CPU until rst.
// Optional feature macro: BIOS_LOADER_ACK_EN (ACK 0xA5 / NAK 0x5A replies).
module bios_loader
  import bios_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RST_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  bios_loader_if.master bus
);

  // Shift register serves both the write-data and the address argument.
  localparam int SHIFT_W = bios_max(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W   = $clog2(SHIFT_W / 8 + 1);
  localparam int RST_W   = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH / 8 - 1);
  localparam logic [RST_W-1:0]      RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [SHIFT_W-1:0]    LANE_MASK = SHIFT_W'(8'hFF);

  bios_state_t           state_q, state_d;
  bios_opcode_t          op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
`ifdef BIOS_LOADER_ACK_EN
  logic                  nak_q, nak_d;
`endif

  logic             fsm_in_ready;
  logic             fsm_valid;
  logic [7:0]       fsm_data;
  logic             booted;
  logic [CNT_W+2:0] lane_sh;
  logic [7:0]       lane_byte;
  logic [CNT_W-1:0] arg_last;

  assign lane_sh   = {byte_cnt_q, 3'b000};
  assign lane_byte = 8'(shift_q >> lane_sh);
  assign arg_last  = (op_q == OP_WRITE) ? DATA_LAST : ADDR_LAST;
  assign booted    = (state_q == S_RUN);

  assign bus.o_rst          = (state_q == S_RST);
  assign bus.o_booted       = booted;
  assign bus.o_read_req     = (state_q == S_RDREQ);
  assign bus.o_read_addr    = addr_q;
  assign bus.o_write_enable = (state_q == S_WRITE);
  assign bus.o_write_addr   = addr_q;
  assign bus.o_write_data   = shift_q[DATA_WIDTH-1:0];
  assign bus.o_byte_enable  = '1;

  // Next-state and stream handshake decode; clk_en gating lives in the register.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    rst_cnt_d    = rst_cnt_q;
`ifdef BIOS_LOADER_ACK_EN
    nak_d        = nak_q;
`endif
    fsm_in_ready = 1'b0;
    fsm_valid    = 1'b0;
    fsm_data     = 8'h00;

    case (state_q)
      S_OPCODE: begin
        fsm_in_ready = 1'b1;
        if (bus.i_valid) begin
          case (bus.i_data)
            OP_NOP:  ;
            OP_BOOT: state_d = S_RUN;
            OP_RST: begin
              rst_cnt_d = '0;
              state_d   = S_RST;
            end
            OP_READ: state_d = S_RDREQ;
            OP_WRITE: begin
              op_d       = OP_WRITE;
              byte_cnt_d = '0;
              state_d    = S_ARG;
            end
            OP_SETADDR: begin
              op_d       = OP_SETADDR;
              byte_cnt_d = '0;
              state_d    = S_ARG;
            end
            default: begin
`ifdef BIOS_LOADER_ACK_EN
              nak_d   = 1'b1;
              state_d = S_ACK;
`endif
            end
          endcase
        end
      end

      S_ARG: begin
        fsm_in_ready = 1'b1;
        if (bus.i_valid) begin
          shift_d = (shift_q & ~(LANE_MASK << lane_sh)) | (SHIFT_W'(bus.i_data) << lane_sh);
          if (byte_cnt_q == arg_last) begin
            byte_cnt_d = '0;
            if (op_q == OP_WRITE) begin
              state_d = S_WRITE;
            end else begin
              addr_d  = shift_d[ADDR_WIDTH-1:0];
              state_d = S_CMD_DONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        addr_d  = addr_q + ADDR_STEP;
        state_d = S_CMD_DONE;
      end

      S_RDREQ: state_d = S_RDWAIT;

      S_RDWAIT: begin
        shift_d    = SHIFT_W'(bus.i_read_data);
        addr_d     = addr_q + ADDR_STEP;
        byte_cnt_d = '0;
        state_d    = S_SEND;
      end

      S_SEND: begin
        fsm_valid = 1'b1;
        fsm_data  = lane_byte;
        if (bus.i_out_ready) begin
          if (byte_cnt_q == DATA_LAST) begin
            byte_cnt_d = '0;
            state_d    = S_OPCODE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = S_CMD_DONE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      S_RUN: ;

`ifdef BIOS_LOADER_ACK_EN
      S_ACK: begin
        fsm_valid = 1'b1;
        fsm_data  = nak_q ? BIOS_NAK_BYTE : BIOS_ACK_BYTE;
        if (bus.i_out_ready) begin
          nak_d   = 1'b0;
          state_d = S_OPCODE;
        end
      end
`endif

      default: state_d = S_OPCODE;
    endcase
  end

  // State register: synchronous reset, frozen while clk_en is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_OPCODE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      rst_cnt_q  <= '0;
`ifdef BIOS_LOADER_ACK_EN
      nak_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
`ifdef BIOS_LOADER_ACK_EN
      nak_q      <= nak_d;
`endif
    end
  end

  bios_stream_mux u_stream_mux (
    .booted_i         (booted),
    .fsm_in_ready_i   (fsm_in_ready),
    .fsm_data_i       (fsm_data),
    .fsm_valid_i      (fsm_valid),
    .host_data_i      (bus.i_data),
    .host_valid_i     (bus.i_valid),
    .host_in_ready_o  (bus.o_in_ready),
    .host_out_data_o  (bus.o_data),
    .host_out_valid_o (bus.o_valid),
    .host_out_ready_i (bus.i_out_ready),
    .cpu_rx_data_o    (bus.o_cpu_rx_data),
    .cpu_rx_valid_o   (bus.o_cpu_rx_valid),
    .cpu_rx_ready_i   (bus.i_cpu_rx_ready),
    .cpu_tx_data_i    (bus.i_cpu_tx_data),
    .cpu_tx_valid_i   (bus.i_cpu_tx_valid),
    .cpu_tx_ready_o   (bus.o_cpu_tx_ready)
  );

endmodule

// File: tb/tb_bios_loader.sv
// Scoreboard bench for bios_loader (default build, BIOS_LOADER_ACK_EN undefined).
module tb_bios_loader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RC = 16;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_en = 1'b1;

  bios_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bios_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RST_CYCLES(RC)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram_word = 32'h0;
  logic [63:0] wr_q [$];
  logic [31:0] rd_q [$];
  logic [7:0]  out_q [$];
  logic [63:0] mon_w;
  logic [31:0] mon_a;
  logic [7:0]  mon_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM model: data appears one enabled cycle after the read strobe.
  always @(posedge clk)
    if (clk_en && bus.o_read_req) bus.i_read_data <= ram_word;

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a sent byte.
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (bus.o_write_enable) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", bus.o_write_addr, bus.o_write_data);
        end else begin
          mon_w = wr_q.pop_front();
          check("write_addr", bus.o_write_addr, mon_w[63:32]);
          check("write_data", bus.o_write_data, mon_w[31:0]);
          check("byte_enable", bus.o_byte_enable, 4'hF);
        end
      end
      if (bus.o_read_req) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_read: got addr 0x%0h, none expected", bus.o_read_addr);
        end else begin
          mon_a = rd_q.pop_front();
          check("read_addr", bus.o_read_addr, mon_a);
        end
      end
      if (!bus.o_booted && bus.o_valid && bus.i_out_ready) begin
        if (out_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out_byte: got 0x%0h, none expected", bus.o_data);
        end else begin
          mon_b = out_q.pop_front();
          check("out_byte", bus.o_data, mon_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one byte and hold it until the DUT accepts it on an enabled edge.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.i_data  = b;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = bus.o_in_ready && clk_en;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus.i_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: byte 0x%0h never accepted", b);
    end
  endtask

  task automatic cmd_setaddr(input logic [31:0] a);
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic cmd_write(input logic [31:0] d);
    send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [31:0] w);
    ram_word = w;
    rd_q.push_back(a);
    for (int i = 0; i < 4; i++) out_q.push_back(w[8*i +: 8]);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (wr_q.size() == 0 && rd_q.size() == 0 && out_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queues", wr_q.size() + rd_q.size() + out_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int hi;
    int en_hi;
    bus.i_data         = 8'h00;
    bus.i_valid        = 1'b0;
    bus.i_out_ready    = 1'b1;
    bus.i_cpu_rx_ready = 1'b0;
    bus.i_cpu_tx_data  = 8'h00;
    bus.i_cpu_tx_valid = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.o_in_ready, 1);
    check("rst_o_rst", bus.o_rst, 0);
    check("rst_booted", bus.o_booted, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_write_en", bus.o_write_enable, 0);
    check("rst_read_req", bus.o_read_req, 0);
    check("rst_byte_en", bus.o_byte_enable, 4'hF);
    check("rst_cpu_rx_valid", bus.o_cpu_rx_valid, 0);
    check("rst_cpu_tx_ready", bus.o_cpu_tx_ready, 0);
    @(posedge clk);
    #1;

    // SETADDR 0x1000, WRITE 0xDEADBEEF: strobe right after the last data byte.
    exp_write(32'h0000_1000, 32'hDEAD_BEEF);
    cmd_setaddr(32'h0000_1000);
    cmd_write(32'hDEAD_BEEF);
    check("write_latency", bus.o_write_enable, 1);
    check("write_busy_ready", bus.o_in_ready, 0);
    drain();

    // READ at 0x1000 with latency checks, then auto-increment to 0x1004.
    cmd_setaddr(32'h0000_1000);
    exp_read(32'h0000_1000, 32'h1122_3344);
    send_byte(8'h03);
    check("read_req_latency", bus.o_read_req, 1);
    @(posedge clk);
    #1;
    check("rdwait_no_valid", bus.o_valid, 0);
    @(posedge clk);
    #1;
    check("first_valid_latency", bus.o_valid, 1);
    drain();
    exp_read(32'h0000_1004, 32'h5566_7788);
    send_byte(8'h03);
    drain();

    // Back-pressure on the output: first byte held, nothing accepted.
    bus.i_out_ready = 1'b0;
    exp_read(32'h0000_1008, 32'hA1B2_C3D4);
    send_byte(8'h03);
    for (int n = 0; n < 10; n++) begin
      if (bus.o_valid) break;
      @(posedge clk);
      #1;
    end
    check("hold_valid_seen", bus.o_valid, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("hold_data", bus.o_data, 8'hD4);
      check("hold_in_ready", bus.o_in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.i_out_ready = 1'b1;
    drain();

    // RST pulse length with clk_en steady.
    send_byte(8'h02);
    hi = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!bus.o_rst) break;
      hi++;
    end
    check("rst_pulse_len", hi, 16);
    check("rst_done_ready", bus.o_in_ready, 1);
    @(posedge clk);
    #1;

    // RST pulse with clk_en alternating: 16 enabled cycles over 32 absolute.
    send_byte(8'h02);
    clk_en = 1'b0;
    hi = 0;
    en_hi = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.o_rst) break;
      hi++;
      if (clk_en) en_hi++;
      @(posedge clk);
      #1;
      clk_en = ~clk_en;
    end
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    check("rst_en_cycles", en_hi, 16);
    check("rst_abs_cycles", hi, 32);
    check("rst_en_done_ready", bus.o_in_ready, 1);

    // Address wrap across the top of the address space.
    exp_write(32'hFFFF_FFFC, 32'h4433_2211);
    exp_write(32'h0000_0000, 32'h8877_6655);
    cmd_setaddr(32'hFFFF_FFFC);
    cmd_write(32'h4433_2211);
    cmd_write(32'h8877_6655);
    drain();
    exp_read(32'h0000_0004, 32'h0BAD_F00D);
    send_byte(8'h03);
    drain();

    // Unknown opcode and NOP are dropped; address untouched.
    send_byte(8'h7F);
    @(negedge clk);
    check("unknown_ready", bus.o_in_ready, 1);
    check("unknown_no_valid", bus.o_valid, 0);
    @(posedge clk);
    #1;
    send_byte(8'h00);
    exp_read(32'h0000_0008, 32'h1234_5678);
    send_byte(8'h03);
    drain();

    // rst mid-SETADDR and mid-WRITE: no strobe, address back to 0.
    send_byte(8'h05);
    send_byte(8'h34);
    send_byte(8'h12);
    pulse_rst();
    check("midcmd_rst_ready", bus.o_in_ready, 1);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_rst();
    repeat (2) @(posedge clk);
    #1;
    exp_read(32'h0000_0000, 32'hCAFE_F00D);
    send_byte(8'h03);
    drain();

    // BOOT: combinational pass-through both ways, not gated by clk_en.
    send_byte(8'h01);
    check("booted", bus.o_booted, 1);
    bus.i_cpu_rx_ready = 1'b1;
    bus.i_data  = 8'h55;
    bus.i_valid = 1'b1;
    #1;
    check("run_rx_data", bus.o_cpu_rx_data, 8'h55);
    check("run_rx_valid", bus.o_cpu_rx_valid, 1);
    check("run_in_ready_hi", bus.o_in_ready, 1);
    bus.i_cpu_rx_ready = 1'b0;
    #1;
    check("run_in_ready_lo", bus.o_in_ready, 0);
    bus.i_cpu_tx_data  = 8'h66;
    bus.i_cpu_tx_valid = 1'b1;
    bus.i_out_ready    = 1'b1;
    #1;
    check("run_tx_data", bus.o_data, 8'h66);
    check("run_tx_valid", bus.o_valid, 1);
    check("run_tx_ready_hi", bus.o_cpu_tx_ready, 1);
    bus.i_out_ready = 1'b0;
    #1;
    check("run_tx_ready_lo", bus.o_cpu_tx_ready, 0);
    clk_en = 1'b0;
    bus.i_data = 8'h77;
    #1;
    check("run_no_clk_en", bus.o_cpu_rx_data, 8'h77);
    clk_en = 1'b1;
    bus.i_data = 8'h02;
    bus.i_cpu_rx_ready = 1'b1;
    bus.i_out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("run_ignores_cmd", bus.o_rst, 0);
    check("run_sticky", bus.o_booted, 1);

    // rst leaves RUN mode.
    bus.i_valid        = 1'b0;
    bus.i_cpu_tx_valid = 1'b0;
    bus.i_cpu_rx_ready = 1'b0;
    pulse_rst();
    @(negedge clk);
    check("unboot_booted", bus.o_booted, 0);
    check("unboot_rx_valid", bus.o_cpu_rx_valid, 0);
    check("unboot_in_ready", bus.o_in_ready, 1);
    check("unboot_valid", bus.o_valid, 0);
    @(posedge clk);
    #1;

    check("wr_q_left", wr_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("out_q_left", out_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bios_loader.md
# bios_loader

Parametrised boot monitor between the host byte stream (UART, AXI-stream style) and the CPU's unified RAM port. While in BOOT mode it decodes a byte-oriented command protocol to set a load address, write and read full RAM words with address auto-increment, and pulse the CPU reset. After a BOOT command it switches permanently to RUN mode and forwards both stream directions to the CPU UART/GPIO channel until the next `rst`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: RAM byte-address width; must be a multiple of 8.
- `DATA_WIDTH`, 32: RAM word width; must be a multiple of 8, and 8 ≤ DATA_WIDTH ≤ 64.
- `RST_CYCLES`, 16: length of the `o_rst` pulse in enabled cycles; must be ≥ 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_en` in 1: cycle enable. When low, all state, counters and handshakes freeze.
- `o_rst` out 1: CPU reset pulse.
- `o_booted` out 1: high in RUN mode.
- `o_read_req` out 1: single-cycle RAM read strobe.
- `o_read_addr` out ADDR_WIDTH: RAM read address.
- `i_read_data` in DATA_WIDTH: RAM read data, valid one enabled cycle after `o_read_req`.
- `o_write_enable` out 1: single-cycle RAM write strobe.
- `o_byte_enable` out DATA_WIDTH/8: byte lanes; all ones when writing.
- `o_write_addr` out ADDR_WIDTH: RAM write address.
- `o_write_data` out DATA_WIDTH: RAM write data.
- `i_data` in 8, `i_valid` in 1, `o_in_ready` out 1: host → block stream.
- `o_data` out 8, `o_valid` out 1, `i_out_ready` in 1: block → host stream.
- `o_cpu_rx_data` out 8, `o_cpu_rx_valid` out 1, `i_cpu_rx_ready` in 1: block → CPU stream (RUN mode only).
- `i_cpu_tx_data` in 8, `i_cpu_tx_valid` in 1, `o_cpu_tx_ready` out 1: CPU → block stream (RUN mode only).

## Operation
Byte accept and send rules:
- An input byte is accepted on an enabled edge where `i_valid & o_in_ready`.
- An output byte is sent on an enabled edge where `o_valid & i_out_ready`.

Opcodes:
- 0x00 NOP: no effect.
- 0x01 BOOT: enter RUN.
- 0x02 RST: pulse `o_rst`.
- 0x03 READ: read one word and send it.
- 0x04 WRITE: followed by DATA_WIDTH/8 data bytes.
- 0x05 SETADDR: followed by ADDR_WIDTH/8 address bytes.
- Any other opcode is dropped silently.
- All multi-byte fields are little-endian.

FSM states:
- S_OPCODE: `o_in_ready`=1. NOP or unknown → S_OPCODE. BOOT → S_RUN. RST → S_RST. READ → S_RDREQ. WRITE or SETADDR → S_ARG with `byte_cnt`=0.
- S_ARG: `o_in_ready`=1. Each accepted byte is shifted into `shift_reg` at byte lane `byte_cnt`. On the last byte: WRITE → S_WRITE; SETADDR loads `addr` and goes to S_OPCODE.
- S_WRITE: one cycle. `o_write_enable`=1, `o_write_addr`=`addr`, `o_write_data`=`shift_reg`, then `addr += DATA_WIDTH/8`. → S_OPCODE.
- S_RDREQ: one cycle. `o_read_req`=1, `o_read_addr`=`addr`. → S_RDWAIT.
- S_RDWAIT: captures `i_read_data` into `shift_reg`, `addr += DATA_WIDTH/8`, `byte_cnt`=0. → S_SEND.
- S_SEND: `o_valid`=1, `o_data`=`shift_reg` lane `byte_cnt`. Holds until accepted; after the last lane → S_OPCODE.
- S_RST: `o_rst`=1 for exactly RST_CYCLES enabled cycles. → S_OPCODE.
- S_RUN: terminal until `rst`. `o_booted`=1. Combinational pass-through: `o_cpu_rx_*` ← `i_data`/`i_valid`, `o_in_ready` ← `i_cpu_rx_ready`, `o_data`/`o_valid` ← `i_cpu_tx_*`, `o_cpu_tx_ready` ← `i_out_ready`. The pass-through is not gated by `clk_en`.

Arithmetic:
- `addr` increments wrap modulo 2^ADDR_WIDTH.
- The low address bits are not forced to alignment.

## Timing
- Reset: state S_OPCODE, `addr`=0, `shift_reg`=0, `byte_cnt`=0. All outputs are 0 except `o_in_ready`=1. `o_byte_enable` is all ones at all times.
- `rst` mid-command, mid-send or in RUN aborts immediately to the reset state. Any partial write is discarded; no RAM strobe is issued.
- WRITE: `o_write_enable` rises on the first enabled cycle after the last data byte is accepted. 1-cycle latency.
- READ: `o_read_req` is one cycle after the opcode is accepted. The first `o_valid` is two cycles later.
- `o_in_ready`=0 in S_WRITE, S_RDREQ, S_RDWAIT, S_SEND and S_RST, so back-to-back commands are back-pressured, never dropped.
- `clk_en` low during S_SEND holds `o_data` and `o_valid` stable.
- `clk_en` low during S_RST extends the `o_rst` pulse in absolute cycles; the count is in enabled cycles.

## Configuration
- `BIOS_LOADER_ACK_EN` defined: after WRITE, SETADDR and RST complete, the block sends one ACK byte 0xA5 (via S_ACK, using the same handshake as S_SEND) before returning to S_OPCODE. An unknown opcode returns NAK byte 0x5A.
- Undefined: no acknowledgements and no S_ACK state. Unknown opcodes are dropped silently.

## Structure
- Shared package `bios_pkg`:
  - `bios_opcode_t`, an 8-bit enum.
  - `bios_state_t` FSM enum.
  - `BIOS_ACK_BYTE` and `BIOS_NAK_BYTE` constants.
- Sub-module `bios_stream_mux`: combinational RUN/BOOT steering of both stream directions, selected by `o_booted`.

## Test plan
- After reset, send 05 00 10 00 00 then 04 EF BE AD DE → a single write strobe, addr 0x00001000, data 0xDEADBEEF, `o_byte_enable`=4'hF.
- Send 05 00 10 00 00, then 03 with RAM returning 0x11223344 → bytes 44,33,22,11 out; the next 03 reads 0x00001004.
- Send 02 with RST_CYCLES=16 → `o_rst` high exactly 16 cycles, then `o_in_ready`=1. With `clk_en` toggling, still 16 enabled cycles.
- Hold `i_out_ready`=0 for 10 cycles during READ → `o_data`=0x44 held stable, with no input accepted; resumes correctly after release.
- SETADDR 0xFFFFFFFC, then two WRITEs → write addresses 0xFFFFFFFC, then 0x00000000.
- Send 01 → `o_booted`=1, byte 0x55 passes to `o_cpu_rx_data` and CPU byte 0x66 passes to `o_data`; assert `rst` → back to BOOT. Also: 0x7F with ACK_EN → NAK 0x5A.
